// File: rtl/eth_bus_pkg.sv
// Shared definitions for the Ethernet controller host-bus master.
//   state_t   : main FSM states
//   sub_t     : sub-phase reported by bus_phase_timer
//   cmd_word  : builds the command word driven during the command phase
//   *_DEF     : default timing / burst-width constants
package eth_bus_pkg;

  localparam int SETUP_CYC_DEF  = 1;
  localparam int STROBE_CYC_DEF = 2;
  localparam int HOLD_CYC_DEF   = 1;
  localparam int LEN_W_DEF      = 8;
  // Wide enough for any sub-phase count up to 256 cycles.
  localparam int CNT_W          = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_C_SETUP  = 3'd1,
    ST_C_STROBE = 3'd2,
    ST_C_HOLD   = 3'd3,
    ST_D_WAIT   = 3'd4,
    ST_D_SETUP  = 3'd5,
    ST_D_STROBE = 3'd6,
    ST_D_HOLD   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    SUB_SETUP  = 2'd0,
    SUB_STROBE = 2'd1,
    SUB_HOLD   = 2'd2
  } sub_t;

  // Byte enables land in the nibble of the half-word selected by offset[1].
  function automatic logic [15:0] cmd_word(input logic [7:0] offset, input logic [1:0] be);
    logic [1:0] w_hi;
    logic [1:0] w_lo;
    w_hi = offset[1] ? be : 2'b00;
    w_lo = offset[1] ? 2'b00 : be;
    return {w_hi, w_lo, 4'b0000, offset};
  endfunction

endpackage

// File: rtl/bus_phase_timer.sv
// Sub-phase sequencer for one bus phase (setup -> strobe -> hold).
//   clk40m, reset  : clock, synchronous active-high reset
//   i_start        : load the setup count; the phase begins the next cycle
//   o_sub          : current sub-phase
//   o_sub_end      : last cycle of the current sub-phase
//   o_phase_done   : last cycle of the hold sub-phase
module bus_phase_timer
  import eth_bus_pkg::*;
#(
  parameter int SETUP_CYC  = SETUP_CYC_DEF,
  parameter int STROBE_CYC = STROBE_CYC_DEF,
  parameter int HOLD_CYC   = HOLD_CYC_DEF
) (
  input  logic clk40m,
  input  logic reset,
  input  logic i_start,
  output sub_t o_sub,
  output logic o_sub_end,
  output logic o_phase_done
);

  logic             r_active;
  sub_t             r_sub;
  logic [CNT_W-1:0] r_cnt;

  assign o_sub        = r_sub;
  assign o_sub_end    = r_active && (r_cnt == '0);
  assign o_phase_done = o_sub_end && (r_sub == SUB_HOLD);

  always_ff @(posedge clk40m) begin
    if (reset) begin
      r_active <= 1'b0;
      r_sub    <= SUB_SETUP;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_sub    <= SUB_SETUP;
      r_cnt    <= CNT_W'(SETUP_CYC - 1);
    end else if (r_active) begin
      if (r_cnt == '0) begin
        case (r_sub)
          SUB_SETUP: begin
            r_sub <= SUB_STROBE;
            r_cnt <= CNT_W'(STROBE_CYC - 1);
          end
          SUB_STROBE: begin
            r_sub <= SUB_HOLD;
            r_cnt <= CNT_W'(HOLD_CYC - 1);
          end
          default: r_active <= 1'b0;
        endcase
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/eth_bus_master.sv
// Host-bus master for the Ethernet MAC/PHY multiplexed CMD/RDN/WRN/SD bus.
// Accepts a request (valid/ready), optionally issues one command word, then
// runs req_len+1 data phases with programmable setup/strobe/hold timing.
//   request : req_valid/req_ready, req_wr, req_offset, req_be, req_len, req_nocmd
//   write   : wr_data/wr_valid/wr_ready, one word per data phase
//   read    : rd_data/rd_valid, one pulse per word, no backpressure
//   bus     : CMD, RDN, WRN, sd_o, sd_oe, sd_i ; status: busy
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | waiting for a request, req_ready high
// ST_C_SETUP  | command word driven, CMD=1, strobes high
// ST_C_STROBE | command word driven, WRN low
// ST_C_HOLD   | command word still driven, strobes high
// ST_D_WAIT   | write: waiting for wr_valid; read: one idle cycle
// ST_D_SETUP  | data phase, CMD=0, write data driven (writes only)
// ST_D_STROBE | WRN (write) or RDN (read) low
// ST_D_HOLD   | strobes high; end of burst or decrement remaining count
module eth_bus_master
  import eth_bus_pkg::*;
#(
  parameter int SETUP_CYC  = SETUP_CYC_DEF,
  parameter int STROBE_CYC = STROBE_CYC_DEF,
  parameter int HOLD_CYC   = HOLD_CYC_DEF,
  parameter int LEN_W      = LEN_W_DEF
) (
  input  logic             clk40m,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wr,
  input  logic [7:0]       req_offset,
  input  logic [1:0]       req_be,
  input  logic [LEN_W-1:0] req_len,
  input  logic             req_nocmd,
  input  logic [15:0]      wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [15:0]      rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             CMD,
  output logic             RDN,
  output logic             WRN,
  output logic [15:0]      sd_o,
  output logic             sd_oe,
  input  logic [15:0]      sd_i
);

  state_t           r_state;
  logic             r_wr;
  logic [15:0]      r_cmd_word;
  logic [15:0]      r_wdata;
  logic [LEN_W-1:0] r_remaining;
  logic             r_req_ready, r_wr_ready, r_rd_valid, r_busy;
  logic             r_cmd, r_rdn, r_wrn, r_sd_oe;
  logic [15:0]      r_rd_data, r_sd_o;

  state_t      w_state_nxt;
  sub_t        w_sub;
  logic        w_sub_end, w_phase_done, w_tmr_start;
  logic        w_accept, w_wr_nxt, w_data_go, w_wr_take;
  logic        w_cmd_phase, w_data_drive, w_rd_capture;
  logic [15:0] w_cmd_nxt, w_wdata_nxt;

  bus_phase_timer #(
    .SETUP_CYC (SETUP_CYC),
    .STROBE_CYC(STROBE_CYC),
    .HOLD_CYC  (HOLD_CYC)
  ) u_timer (
    .clk40m      (clk40m),
    .reset       (reset),
    .i_start     (w_tmr_start),
    .o_sub       (w_sub),
    .o_sub_end   (w_sub_end),
    .o_phase_done(w_phase_done)
  );

  // Outputs are registered from the next state, so the "next" view of the
  // latched request is needed on the accept / data-latch edges.
  assign w_accept     = req_valid && r_req_ready;
  assign w_wr_nxt     = w_accept ? req_wr : r_wr;
  assign w_cmd_nxt    = w_accept ? cmd_word(req_offset, req_be) : r_cmd_word;
  assign w_wr_take    = (r_state == ST_D_WAIT) && r_wr && wr_valid;
  assign w_wdata_nxt  = w_wr_take ? wr_data : r_wdata;
  assign w_data_go    = (r_state == ST_D_WAIT) && (!r_wr || wr_valid);
  assign w_tmr_start  = (w_accept && !req_nocmd) || w_data_go;
  assign w_rd_capture = (r_state == ST_D_STROBE) && w_sub_end && !r_wr;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:
        if (w_accept) w_state_nxt = req_nocmd ? ST_D_WAIT : ST_C_SETUP;
      ST_C_SETUP, ST_C_STROBE, ST_C_HOLD:
        if (w_phase_done)   w_state_nxt = ST_D_WAIT;
        else if (w_sub_end) w_state_nxt = (w_sub == SUB_SETUP) ? ST_C_STROBE : ST_C_HOLD;
      ST_D_WAIT:
        if (w_data_go) w_state_nxt = ST_D_SETUP;
      ST_D_SETUP, ST_D_STROBE, ST_D_HOLD:
        if (w_phase_done)   w_state_nxt = (r_remaining == '0) ? ST_IDLE : ST_D_WAIT;
        else if (w_sub_end) w_state_nxt = (w_sub == SUB_SETUP) ? ST_D_STROBE : ST_D_HOLD;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_cmd_phase  = (w_state_nxt == ST_C_SETUP) || (w_state_nxt == ST_C_STROBE) ||
                        (w_state_nxt == ST_C_HOLD);
  assign w_data_drive = w_wr_nxt && ((w_state_nxt == ST_D_SETUP) ||
                        (w_state_nxt == ST_D_STROBE) || (w_state_nxt == ST_D_HOLD));

  always_ff @(posedge clk40m) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_wr        <= 1'b0;
      r_cmd_word  <= '0;
      r_wdata     <= '0;
      r_remaining <= '0;
      r_req_ready <= 1'b0;
      r_wr_ready  <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_busy      <= 1'b0;
      r_cmd       <= 1'b1;
      r_rdn       <= 1'b1;
      r_wrn       <= 1'b1;
      r_sd_oe     <= 1'b0;
      r_sd_o      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr       <= w_wr_nxt;
      r_cmd_word <= w_cmd_nxt;
      r_wdata    <= w_wdata_nxt;
      // Decrement only when another data phase follows, so the count never wraps.
      if (w_accept)
        r_remaining <= req_len;
      else if ((r_state == ST_D_HOLD) && w_phase_done && (r_remaining != '0))
        r_remaining <= r_remaining - LEN_W'(1);
      r_req_ready <= (w_state_nxt == ST_IDLE);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_wr_ready  <= (w_state_nxt == ST_D_WAIT) && w_wr_nxt;
      r_cmd       <= (w_state_nxt == ST_IDLE) || w_cmd_phase;
      r_wrn       <= !((w_state_nxt == ST_C_STROBE) ||
                       ((w_state_nxt == ST_D_STROBE) && w_wr_nxt));
      r_rdn       <= !((w_state_nxt == ST_D_STROBE) && !w_wr_nxt);
      r_sd_oe     <= w_cmd_phase || w_data_drive;
      r_sd_o      <= w_cmd_phase ? w_cmd_nxt : (w_data_drive ? w_wdata_nxt : 16'h0000);
      r_rd_valid  <= w_rd_capture;
      if (w_rd_capture) r_rd_data <= sd_i;
    end
  end

  assign req_ready = r_req_ready;
  assign wr_ready  = r_wr_ready;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign busy      = r_busy;
  assign CMD       = r_cmd;
  assign RDN       = r_rdn;
  assign WRN       = r_wrn;
  assign sd_oe     = r_sd_oe;
  assign sd_o      = r_sd_o;

endmodule
